// File: rtl/pc_ras_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_ras_unit_pkg
// Shared types and constants for the program-counter / return-address-stack
// unit.
//   pcMux      : next-PC source select (encoding is fixed here)
//   word_t     : 32-bit machine word
//   WORD_BYTES : bytes per instruction word, the sequential PC increment
// -----------------------------------------------------------------------------
package pc_ras_unit_pkg;

  typedef logic [31:0] word_t;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    PC_NPC = 3'd0,
    PC_BR  = 3'd1,
    PC_J   = 3'd2,
    PC_JR  = 3'd3,
    PC_RAS = 3'd4
  } pcMux;

endpackage : pc_ras_unit_pkg

// File: rtl/pc_ras_unit_ras.sv
// -----------------------------------------------------------------------------
// pc_ras_unit_ras (ras_stack)
// Circular return-address stack with a top pointer, valid-entry count and a
// sticky overflow flag.
//   clk, rst : clock, synchronous active-high reset (control state only)
//   push     : write wdata as the new top entry
//   pop      : discard the top entry (ignored while empty)
//   wdata    : return address to push
//   top      : current top entry, RESET_PC while empty
//   cnt      : number of valid entries, saturates at RAS_DEPTH
//   ovf      : sticky, set by a push into a full stack
// -----------------------------------------------------------------------------
module pc_ras_unit_ras #(
  parameter int              PC_W      = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  localparam int             PTR_W     = $clog2(RAS_DEPTH),
  localparam int             CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  wdata,
  output logic [PC_W-1:0]  top,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             empty, full, do_pop;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(RAS_DEPTH));
  assign do_pop = pop & ~empty;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push && do_pop) begin
      // Call in the same cycle as a return: replace the top in place.
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (push) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q + 1'b1;
      ptr_d  = ptr_q + 1'b1;
      // A full stack wraps onto its oldest entry and flags the loss.
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end else if (do_pop) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage carries no reset; it is only read while cnt is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wdata;
  end

  assign top = empty ? RESET_PC : mem_q[ptr_q];
  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule : pc_ras_unit_ras

// File: rtl/pc_ras_unit.sv
// -----------------------------------------------------------------------------
// pc_ras_unit
// Fetch program counter with next-PC selection, return-address stack and a
// later-stage redirect port.
//   CLK, RST : clock, synchronous active-high reset
//   pcEn     : advance enable (0 = stall)
//   pcSel    : next-PC source (PC_NPC/PC_BR/PC_J/PC_JR/PC_RAS, PC_RAS pops)
//   immJ26   : J-type immediate
//   ext32    : sign-extended branch offset in words
//   rdat     : register read data for JR
//   rasPush  : push cpc+4 (JAL)
//   redirEn  : redirect from a later stage, overrides stall and select
//   redirPc  : redirect target
//   cpc      : current PC
//   pc4      : cpc+4
//   rasTop   : top of return stack, RESET_PC when empty
//   rasCnt   : valid return-stack entries
//   rasOvf   : sticky return-stack overflow
// Optional build macro PC_ALIGN_CHECK_EN adds a sticky 'misalign' output and
// suppresses any PC update whose target is not word aligned.
// -----------------------------------------------------------------------------
module pc_ras_unit
  import pc_ras_unit_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4,
  localparam int             CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pcEn,
  input  pcMux             pcSel,
  input  logic [25:0]      immJ26,
  input  logic [PC_W-1:0]  ext32,
  input  logic [PC_W-1:0]  rdat,
  input  logic             rasPush,
  input  logic             redirEn,
  input  logic [PC_W-1:0]  redirPc,
  output logic [PC_W-1:0]  cpc,
  output logic [PC_W-1:0]  pc4,
`ifdef PC_ALIGN_CHECK_EN
  output logic             misalign,
`endif
  output logic [PC_W-1:0]  rasTop,
  output logic [CNT_W-1:0] rasCnt,
  output logic             rasOvf
);

  // Low 28 bits of a J target come from the immediate, the rest from pc4.
  localparam logic [PC_W-1:0] J_MASK = PC_W'(28'hFFF_FFFF);

  logic [PC_W-1:0] cpc_q, cpc_d;
  logic [PC_W-1:0] npc;
  logic [PC_W-1:0] tgt;
  logic            bad_tgt;
  logic            ras_push, ras_pop;

  assign pc4 = cpc_q + PC_W'(WORD_BYTES);

  always_comb begin
    npc = pc4;
    case (pcSel)
      PC_NPC:  npc = pc4;
      PC_BR:   npc = pc4 + (ext32 << 2);
      PC_J:    npc = (pc4 & ~J_MASK) | PC_W'({immJ26, 2'b00});
      PC_JR:   npc = rdat;
      PC_RAS:  npc = rasTop;
      default: npc = pc4;
    endcase
  end

  // Target that would be loaded this cycle, used by the alignment check.
  assign tgt = redirEn ? redirPc : npc;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign bad_tgt    = (redirEn | pcEn) & (tgt[1:0] != 2'b00);
  assign misalign_d = misalign_q | bad_tgt;
  always_ff @(posedge CLK) begin
    if (RST) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
  assign misalign = misalign_q;
`else
  assign bad_tgt = 1'b0;
`endif

  always_comb begin
    cpc_d = cpc_q;
    if (!bad_tgt && (redirEn || pcEn)) cpc_d = tgt;
  end

  // Stack traffic only on a real, non-redirected, accepted advance.
  assign ras_push = pcEn & ~redirEn & ~bad_tgt & rasPush;
  assign ras_pop  = pcEn & ~redirEn & ~bad_tgt & (pcSel == PC_RAS);

  always_ff @(posedge CLK) begin
    if (RST) cpc_q <= RESET_PC;
    else     cpc_q <= cpc_d;
  end

  pc_ras_unit_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_ras (
    .clk   (CLK),
    .rst   (RST),
    .push  (ras_push),
    .pop   (ras_pop),
    .wdata (pc4),
    .top   (rasTop),
    .cnt   (rasCnt),
    .ovf   (rasOvf)
  );

  assign cpc = cpc_q;

endmodule : pc_ras_unit
